muldiv_sequencer: RTL

Multi-cycle multiply/divide controller for the CPU datapath. It replaces the single-cycle `*`, `/` and `%` paths of the ALU with an iterative shift-add multiplier and restoring divider, sequenced by a start/busy/done handshake. Results are held in HI/LO registers until the next accepted operation. The pipeline stalls on `busy` and takes results when `done` pulses.

---
 rtl/muldiv_if.sv | 15 +
 rtl/muldiv_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake and operand/result bus of the multiply/divide sequencer
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic             op;
   logic             sign;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic             dbz;
   modport master (output start, op, sign, X, Y, input busy, done, lo, hi, dbz);
   modport slave  (input start, op, sign, X, Y, output busy, done, lo, hi, dbz);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiplier and restoring divider; MULDIV_EARLY_OUT_EN ends multiply once the multiplier runs out
module muldiv_sequencer #(parameter int WIDTH = 32) (
   input logic    clk,
   input logic    rst,
   muldiv_if.slave bus
);
   localparam int W = WIDTH;
   typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;
   state_t state;
   logic op_r, sign_r, neg_lo, neg_hi, busy_r, done_r, dbz_r, last;
   logic [W-1:0] x_r, y_r, b, lo_r, hi_r, x_mag, y_mag, q_fix, r_fix;
   logic [2*W-1:0] acc, mcand, acc_mul, acc_div, prod;
   logic [2*W:0] sh;
   logic [W+1:0] diff;
   logic [5:0] cnt;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.lo   = lo_r;
   assign bus.hi   = hi_r;
   assign bus.dbz  = dbz_r;
   // Operand magnitudes, one multiply/divide step, sign fixup and loop exit
   always_comb begin
      x_mag   = (sign_r && x_r[W-1]) ? -x_r : x_r;
      y_mag   = (sign_r && y_r[W-1]) ? -y_r : y_r;
      acc_mul = acc + (b[0] ? mcand : '0);
      sh      = {acc, 1'b0};
      diff    = {1'b0, sh[2*W:W]} - {2'b00, b};
      acc_div = diff[W+1] ? sh[2*W-1:0] : {diff[W-1:0], sh[W-1:1], 1'b1};
      prod    = neg_lo ? -acc : acc;
      q_fix   = neg_lo ? -acc[W-1:0] : acc[W-1:0];
      r_fix   = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
`ifdef MULDIV_EARLY_OUT_EN
      last    = (cnt == 6'd1) || (!op_r && (b >> 1) == '0);
`else
      last    = cnt == 6'd1;
`endif
   end
   // Sequencer FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         lo_r   <= '0;
         hi_r   <= '0;
         dbz_r  <= 1'b0;
         op_r   <= 1'b0;
         sign_r <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         x_r    <= '0;
         y_r    <= '0;
         b      <= '0;
         acc    <= '0;
         mcand  <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               op_r   <= bus.op;
               sign_r <= bus.sign;
               x_r    <= bus.X;
               y_r    <= bus.Y;
               busy_r <= 1'b1;
               state  <= PREP;
            end
            PREP: begin
               neg_lo <= sign_r & (x_r[W-1] ^ y_r[W-1]);
               neg_hi <= sign_r & x_r[W-1];
               cnt    <= 6'(W);
               acc    <= op_r ? {{W{1'b0}}, x_mag} : '0;
               mcand  <= {{W{1'b0}}, x_mag};
               b      <= y_mag;
               if (op_r && y_r == '0) begin
                  lo_r   <= '1;
                  hi_r   <= x_r;
                  dbz_r  <= 1'b1;
                  done_r <= 1'b1;
                  state  <= DONE;
               end else
                  state  <= CALC;
            end
            CALC: begin
               cnt   <= cnt - 6'd1;
               acc   <= op_r ? acc_div : acc_mul;
               mcand <= mcand << 1;
               b     <= op_r ? b : b >> 1;
               state <= last ? FIXUP : CALC;
            end
            FIXUP: begin
               lo_r   <= op_r ? q_fix : prod[W-1:0];
               hi_r   <= op_r ? r_fix : prod[2*W-1:W];
               dbz_r  <= 1'b0;
               done_r <= 1'b1;
               state  <= DONE;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule
